// File: rtl/axi_pkg.sv
// AXI4-Lite response codes and the default 32-bit AXI4-Lite request/response structs.
// Shared by the register-file slave and any crossbar it is attached to.
package axi_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } axil_ax_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } axil_w_t;

   typedef struct packed {
      resp_t resp;
   } axil_b_t;

   typedef struct packed {
      logic [31:0] data;
      resp_t       resp;
   } axil_r_t;

   typedef struct packed {
      axil_ax_t aw;
      logic     aw_valid;
      axil_w_t  w;
      logic     w_valid;
      logic     b_ready;
      axil_ax_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axil_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      axil_b_t b;
      logic    b_valid;
      logic    ar_ready;
      axil_r_t r;
      logic    r_valid;
   } axil_resp_t;

endpackage

// File: rtl/axi_lite_regfile_slv.sv
// AXI4-Lite slave exposing NoRegs data-width registers with per-register read-only masks,
// hardware load ports and write-commit pulses; read and write paths run independently.
module axi_lite_regfile_slv
   import axi_pkg::*;
#(
   parameter int unsigned                         NoRegs       = 32'd4,
   parameter int unsigned                         AxiAddrWidth = 32'd32,
   parameter int unsigned                         AxiDataWidth = 32'd32,
   parameter logic [NoRegs-1:0]                   ReadOnly     = '0,
   parameter logic [NoRegs-1:0][AxiDataWidth-1:0] RegRstVal    = '0,
   parameter type                                 axi_req_t    = axil_req_t,
   parameter type                                 axi_resp_t   = axil_resp_t
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  axi_req_t                             slv_req_i,
   output axi_resp_t                            slv_resp_o,
   output logic [NoRegs-1:0][AxiDataWidth-1:0]  reg_q_o,
   input  logic [NoRegs-1:0]                    reg_load_i,
   input  logic [NoRegs-1:0][AxiDataWidth-1:0]  reg_d_i,
   output logic [NoRegs-1:0]                    wr_pulse_o
);

   localparam int unsigned StrbWidth = AxiDataWidth / 8;
   localparam int unsigned AddrShift = $clog2(StrbWidth);

   typedef logic [AxiAddrWidth-1:0] addr_t;
   typedef logic [AxiDataWidth-1:0] data_t;
   typedef logic [StrbWidth-1:0]    strb_t;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_RESP} r_state_e;

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;

   logic  aw_held_q, w_held_q;
   addr_t aw_addr_q;
   data_t w_data_q;
   strb_t w_strb_q;
   resp_t bresp_q;

   data_t rdata_q;
   resp_t rresp_q;

   logic [NoRegs-1:0][AxiDataWidth-1:0] reg_q, reg_next;
   logic [NoRegs-1:0]                   pulse_q, wr_sel;

   logic  aw_ready, w_ready, aw_hs, w_hs, commit;
   addr_t wr_addr, wr_idx;
   data_t wr_data;
   strb_t wr_strb;
   logic  wr_in_range, wr_ro, wr_err, wr_apply;

   logic  ar_ready, ar_hs, rd_in_range;
   addr_t rd_idx;
   data_t rd_val;

   logic  unused_prot;
   assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

   // AW and W may arrive in any order; the live channel bypasses its holding register
   assign aw_ready = (w_state_q == W_IDLE) && !aw_held_q && !rst_i;
   assign w_ready  = (w_state_q == W_IDLE) && !w_held_q && !rst_i;
   assign aw_hs    = slv_req_i.aw_valid && aw_ready;
   assign w_hs     = slv_req_i.w_valid && w_ready;
   assign commit   = (w_state_q == W_IDLE) && !rst_i
                     && (aw_held_q || aw_hs) && (w_held_q || w_hs);

   assign wr_addr  = aw_held_q ? aw_addr_q : addr_t'(slv_req_i.aw.addr);
   assign wr_data  = w_held_q ? w_data_q : data_t'(slv_req_i.w.data);
   assign wr_strb  = w_held_q ? w_strb_q : strb_t'(slv_req_i.w.strb);
   assign wr_idx   = wr_addr >> AddrShift;
   assign wr_in_range = wr_idx < addr_t'(NoRegs);

   always_comb begin
      wr_ro = 1'b0;
      for (int unsigned k = 0; k < NoRegs; k++) begin
         if (wr_idx == addr_t'(k)) wr_ro = ReadOnly[k];
      end
   end

   assign wr_err   = !wr_in_range || wr_ro;
   assign wr_apply = commit && !wr_err && (wr_strb != '0);

   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (commit) w_state_d = W_RESP;
         W_RESP:  if (slv_req_i.b_ready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else begin
            if (aw_hs) begin
               aw_held_q <= 1'b1;
               aw_addr_q <= addr_t'(slv_req_i.aw.addr);
            end
            if (w_hs) begin
               w_held_q <= 1'b1;
               w_data_q <= data_t'(slv_req_i.w.data);
               w_strb_q <= strb_t'(slv_req_i.w.strb);
            end
         end
      end
   end

   // Hardware load forms the base value; strobed AXI bytes then override it
   always_comb begin
      reg_next = reg_q;
      wr_sel   = '0;
      for (int unsigned k = 0; k < NoRegs; k++) begin
         if (reg_load_i[k]) reg_next[k] = reg_d_i[k];
         if (wr_apply && (wr_idx == addr_t'(k))) begin
            wr_sel[k] = 1'b1;
            for (int unsigned b = 0; b < StrbWidth; b++) begin
               if (wr_strb[b]) reg_next[k][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         reg_q   <= RegRstVal;
         pulse_q <= '0;
      end else begin
         reg_q   <= reg_next;
         pulse_q <= wr_sel;
      end
   end

   assign ar_ready    = (r_state_q == R_IDLE) && !rst_i;
   assign ar_hs       = slv_req_i.ar_valid && ar_ready;
   assign rd_idx      = addr_t'(slv_req_i.ar.addr) >> AddrShift;
   assign rd_in_range = rd_idx < addr_t'(NoRegs);

   always_comb begin
      rd_val = '0;
      for (int unsigned k = 0; k < NoRegs; k++) begin
         if (rd_idx == addr_t'(k)) rd_val = reg_q[k];
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_hs) r_state_d = R_RESP;
         R_RESP:  if (slv_req_i.r_ready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         if (ar_hs) begin
            rdata_q <= rd_in_range ? rd_val : '0;
            rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = aw_ready;
      slv_resp_o.w_ready  = w_ready;
      slv_resp_o.b_valid  = (w_state_q == W_RESP) && !rst_i;
      slv_resp_o.b.resp   = bresp_q;
      slv_resp_o.ar_ready = ar_ready;
      slv_resp_o.r_valid  = (r_state_q == R_RESP) && !rst_i;
      slv_resp_o.r.data   = rdata_q;
      slv_resp_o.r.resp   = rresp_q;
   end

   assign reg_q_o    = reg_q;
   assign wr_pulse_o = pulse_q & ~{NoRegs{rst_i}};

endmodule

// File: tb/tb_axi_lite_regfile_slv.sv
// Randomized scoreboard bench for axi_lite_regfile_slv: driver tasks push expected B/R
// responses, a negedge monitor pops and compares them against what the slave presents.
module tb_axi_lite_regfile_slv;
   import axi_pkg::*;

   localparam int unsigned N = 4;
   localparam logic [N-1:0] RO = 4'b0001;
   localparam logic [N-1:0][31:0] RST = {32'hCAFE_0003, 32'h1122_3344, 32'hA5A5_0001, 32'h0BAD_0000};

   logic clk = 1'b0;
   logic rst;
   axil_req_t  req;
   axil_resp_t resp;
   logic [N-1:0][31:0] reg_q, reg_d;
   logic [N-1:0]       reg_load, pulse;

   always #5 clk = ~clk;

   axi_lite_regfile_slv #(
      .NoRegs(N), .AxiAddrWidth(32), .AxiDataWidth(32), .ReadOnly(RO), .RegRstVal(RST),
      .axi_req_t(axil_req_t), .axi_resp_t(axil_resp_t)
   ) dut (
      .clk_i(clk), .rst_i(rst), .slv_req_i(req), .slv_resp_o(resp), .reg_q_o(reg_q),
      .reg_load_i(reg_load), .reg_d_i(reg_d), .wr_pulse_o(pulse)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] model [N];
   int exp_pulse [N];
   int got_pulse [N];
   logic [1:0]  b_exp_q [$];
   logic [33:0] r_exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, want);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event did not occur as required", name);
   endtask

   task automatic check_regs(input string name);
      for (int k = 0; k < N; k++) check(name, reg_q[k], model[k]);
   endtask

   // Monitor: compare responses at handshake, and stability while stalled
   logic b_hold, r_hold;
   logic [1:0]  b_prev;
   logic [33:0] r_prev;
   always @(negedge clk) begin
      if (rst) begin
         b_hold = 1'b0;
         r_hold = 1'b0;
      end else begin
         for (int k = 0; k < N; k++) if (pulse[k]) got_pulse[k]++;
         if (b_hold) begin
            check("b_valid_held", resp.b_valid, 1);
            check("bresp_stable", resp.b.resp, b_prev);
         end
         b_hold = 1'b0;
         if (resp.b_valid) begin
            if (req.b_ready) begin
               if (b_exp_q.size() == 0) fail_now("b_unexpected");
               else check("bresp", resp.b.resp, b_exp_q.pop_front());
            end else begin
               b_hold = 1'b1;
               b_prev = resp.b.resp;
            end
         end
         if (r_hold) begin
            check("r_valid_held", resp.r_valid, 1);
            check("r_stable", {resp.r.resp, resp.r.data}, r_prev);
         end
         r_hold = 1'b0;
         if (resp.r_valid) begin
            if (req.r_ready) begin
               if (r_exp_q.size() == 0) fail_now("r_unexpected");
               else check("rresp_rdata", {resp.r.resp, resp.r.data}, r_exp_q.pop_front());
            end else begin
               r_hold = 1'b1;
               r_prev = {resp.r.resp, resp.r.data};
            end
         end
      end
   end

   // lead > 0: W issued that many cycles before AW; lead < 0: AW first
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int bdelay, input bit chk_wready);
      int unsigned idx;
      logic [1:0] exp;
      bit aw_done, w_done, hs_aw, hs_w, got;
      int aw_t, w_t, t;
      idx = addr >> 2;
      if (idx >= N) exp = RESP_SLVERR;
      else if (RO[idx]) exp = RESP_SLVERR;
      else exp = RESP_OKAY;
      b_exp_q.push_back(exp);
      aw_t = (lead < 0) ? 0 : lead;
      w_t  = (lead < 0) ? -lead : 0;
      aw_done = 0; w_done = 0; t = 0;
      while (!(aw_done && w_done) && t < 60) begin
         if (t == aw_t) begin req.aw_valid = 1'b1; req.aw.addr = addr; end
         if (t == w_t) begin req.w_valid = 1'b1; req.w.data = data; req.w.strb = strb; end
         @(negedge clk);
         if (chk_wready && w_done && !aw_done) check("w_ready_low_while_w_held", resp.w_ready, 0);
         hs_aw = req.aw_valid && resp.aw_ready;
         hs_w  = req.w_valid && resp.w_ready;
         @(posedge clk); #1;
         if (hs_aw) begin aw_done = 1; req.aw_valid = 1'b0; end
         if (hs_w) begin w_done = 1; req.w_valid = 1'b0; end
         t++;
      end
      if (!(aw_done && w_done)) begin
         fail_now("write_handshake_timeout");
         req.aw_valid = 1'b0; req.w_valid = 1'b0;
         void'(b_exp_q.pop_back());
         return;
      end
      t = 0; got = 0;
      if (bdelay == 0) req.b_ready = 1'b1;
      while (!got && t < 60) begin
         @(negedge clk);
         if (t == 0) check("b_valid_one_cycle_after_commit", resp.b_valid, 1);
         got = resp.b_valid && req.b_ready;
         @(posedge clk); #1;
         t++;
         if (t == bdelay) req.b_ready = 1'b1;
      end
      req.b_ready = 1'b0;
      if (!got) begin
         fail_now("b_timeout");
         return;
      end
      if (exp == RESP_OKAY && strb != 4'h0) begin
         for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
         exp_pulse[idx]++;
      end
      check_regs("regs_after_write");
   endtask

   task automatic axi_read(input logic [31:0] addr, input int rdelay);
      int unsigned idx;
      bit got;
      int t;
      idx = addr >> 2;
      if (idx >= N) r_exp_q.push_back({RESP_SLVERR, 32'h0});
      else r_exp_q.push_back({RESP_OKAY, model[idx]});
      req.ar_valid = 1'b1; req.ar.addr = addr;
      t = 0; got = 0;
      while (!got && t < 60) begin
         @(negedge clk);
         got = resp.ar_ready;
         @(posedge clk); #1;
         t++;
      end
      req.ar_valid = 1'b0;
      if (!got) begin
         fail_now("ar_timeout");
         void'(r_exp_q.pop_back());
         return;
      end
      t = 0; got = 0;
      if (rdelay == 0) req.r_ready = 1'b1;
      while (!got && t < 60) begin
         @(negedge clk);
         got = resp.r_valid && req.r_ready;
         @(posedge clk); #1;
         t++;
         if (t == rdelay) req.r_ready = 1'b1;
      end
      req.r_ready = 1'b0;
      if (!got) fail_now("r_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      req = '0; reg_load = '0; reg_d = '0; rst = 1'b1;
      for (int k = 0; k < N; k++) begin
         model[k] = RST[k]; exp_pulse[k] = 0; got_pulse[k] = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_aw_ready", resp.aw_ready, 0);
      check("rst_w_ready", resp.w_ready, 0);
      check("rst_ar_ready", resp.ar_ready, 0);
      check("rst_b_valid", resp.b_valid, 0);
      check("rst_r_valid", resp.r_valid, 0);
      check("rst_wr_pulse", pulse, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("idle_aw_ready", resp.aw_ready, 1);
      check("idle_w_ready", resp.w_ready, 1);
      check("idle_ar_ready", resp.ar_ready, 1);
      check_regs("reset_values");
      @(posedge clk); #1;

      axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      axi_write(32'h8, 32'h000000AA, 4'h1, 3, 1, 1);
      check("reg2_byte_merge", reg_q[2], 32'h112233AA);
      axi_write(32'h10, 32'h12345678, 4'hF, 0, 0, 0);
      axi_write(32'h0, 32'h55555555, 4'hF, -2, 0, 0);
      axi_read(32'h10, 0);
      axi_read(32'h0, 1);
      axi_write(32'h4, 32'hFFFFFFFF, 4'h0, 1, 0, 0);

      fork
         axi_write(32'hC, 32'h01020304, 4'hF, 0, 5, 0);
         axi_read(32'h4, 0);
      join
      fork
         axi_write(32'h4, 32'h600DF00D, 4'hF, 0, 0, 0);
         axi_read(32'h4, 2);
      join

      reg_d[3] = 32'hFFFFFFFF; reg_load[3] = 1'b1; model[3] = 32'hFFFFFFFF;
      fork
         axi_write(32'hC, 32'h00000000, 4'h3, 0, 0, 0);
         begin @(posedge clk); #1 reg_load = '0; end
      join
      check("reg3_load_vs_write", reg_q[3], 32'hFFFF0000);

      reg_d[0] = 32'h0F0F0F0F; reg_load[0] = 1'b1;
      @(posedge clk); #1 reg_load = '0; model[0] = 32'h0F0F0F0F;
      @(negedge clk); check_regs("hw_load_readonly");
      @(posedge clk); #1;

      // Reset while B is pending: no response, registers back to reset values
      req.aw_valid = 1'b1; req.aw.addr = 32'h4;
      req.w_valid = 1'b1; req.w.data = 32'h77778888; req.w.strb = 4'hF;
      @(negedge clk); check("abort_aw_ready", resp.aw_ready, 1);
      @(posedge clk); #1 req.aw_valid = 1'b0; req.w_valid = 1'b0;
      exp_pulse[1]++;
      @(negedge clk); check("abort_b_pending", resp.b_valid, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("abort_b_dropped", resp.b_valid, 0);
      check("abort_aw_ready_in_reset", resp.aw_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < N; k++) model[k] = RST[k];
      @(negedge clk);
      check("abort_no_b_after_reset", resp.b_valid, 0);
      check_regs("regs_after_abort_reset");
      @(posedge clk); #1;
      axi_write(32'h4, 32'h13579BDF, 4'hF, -1, 0, 0);

      repeat (40) begin
         a = ($urandom_range(0, 5) << 2) | $urandom_range(0, 3);
         d = $urandom;
         if ($urandom_range(0, 1) == 1)
            axi_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                      int'($urandom_range(0, 3)), 0);
         else
            axi_read(a, int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      check("b_queue_drained", b_exp_q.size(), 0);
      check("r_queue_drained", r_exp_q.size(), 0);
      for (int k = 0; k < N; k++) check("wr_pulse_count", got_pulse[k], exp_pulse[k]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
